mm_control_unit: RTL and testbench

Multicycle control FSM for the memory-to-memory datapath. It sits directly upstream of `stage_6`: it reads the latched opcode (`OPOut`) and the branch condition (`isTrue`), and drives every datapath control input, one microstep per clock. Each instruction is sequenced from FETCH through operand-address fetch, operand load, execute and write-back. The FSM then returns to FETCH.

---
 rtl/mm_control_unit.sv | 209 ++++++++++++++++++++
 tb/tb_mm_control_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mm_control_unit.sv
// mm_control_unit: multicycle control FSM for the memory-to-memory datapath.
// Sequences each instruction FETCH -> operand address -> operand load ->
// execute -> write-back and drives every datapath control, one microstep
// per clock. Controls are decoded from the state register and forced to 0
// while reset is low.
// Optional feature macro: MM_CTRL_HALT_EN (halt class parks the FSM in HALT;
// when undefined the halt class is a two-cycle NOP and halted is tied 0).
module mm_control_unit #(
    parameter int unsigned OP_W = 8
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            isTrue,
    output logic            inputPC,
    output logic            valA,
    output logic            writeSP,
    output logic            regOrPC,
    output logic            branch,
    output logic [1:0]      memAddr,
    output logic [1:0]      memWriteData,
    output logic [1:0]      ALUsrca,
    output logic [1:0]      ALUsrcb,
    output logic [3:0]      ALUOp,
    output logic            writeOp,
    output logic            writeA,
    output logic            writeB,
    output logic            writeDest,
    output logic            writePC,
    output logic            writeMem,
    output logic            halted,
    output logic [3:0]      state_dbg
);

    localparam int unsigned ST_W = 4;

    localparam logic [ST_W-1:0] S_FETCH  = 4'd0;
    localparam logic [ST_W-1:0] S_ADDR_A = 4'd1;
    localparam logic [ST_W-1:0] S_ADDR_B = 4'd2;
    localparam logic [ST_W-1:0] S_LOAD_A = 4'd3;
    localparam logic [ST_W-1:0] S_LOAD_B = 4'd4;
    localparam logic [ST_W-1:0] S_EXEC   = 4'd5;
    localparam logic [ST_W-1:0] S_MOV    = 4'd6;
    localparam logic [ST_W-1:0] S_WB     = 4'd7;
    localparam logic [ST_W-1:0] S_CMP    = 4'd8;
    localparam logic [ST_W-1:0] S_BR     = 4'd9;
    localparam logic [ST_W-1:0] S_HALT   = 4'd10;

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_BR   = 2'b01;
    localparam logic [1:0] CLS_MOVE = 2'b10;
    localparam logic [1:0] CLS_HALT = 2'b11;

    logic [ST_W-1:0] state_q;
    logic [ST_W-1:0] state_d;
    logic [1:0]      op_class;
    logic [3:0]      alu_fn;
    logic            op_unused;

    assign op_class  = op[7:6];
    assign alu_fn    = op[3:0];
    // Opcode bits outside class/function fields carry no control meaning.
    assign op_unused = ^op;

    // State register; reset parks at FETCH.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection from the current state and opcode class.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_ADDR_A;
            S_ADDR_A: begin
                case (op_class)
                    CLS_MOVE: state_d = S_LOAD_A;
                    CLS_HALT: begin
`ifdef MM_CTRL_HALT_EN
                        state_d = S_HALT;
`else
                        state_d = S_FETCH;
`endif
                    end
                    default:  state_d = S_ADDR_B;
                endcase
            end
            S_ADDR_B: state_d = S_LOAD_A;
            S_LOAD_A: state_d = (op_class == CLS_MOVE) ? S_MOV : S_LOAD_B;
            S_LOAD_B: begin
                case (op_class)
                    CLS_ALU: state_d = S_EXEC;
                    CLS_BR:  state_d = S_CMP;
                    default: state_d = S_FETCH;
                endcase
            end
            S_EXEC:   state_d = S_WB;
            S_MOV:    state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_CMP:    state_d = S_BR;
            S_BR:     state_d = S_FETCH;
            S_HALT: begin
`ifdef MM_CTRL_HALT_EN
                state_d = S_HALT;
`else
                state_d = S_FETCH;
`endif
            end
            default:  state_d = S_FETCH;
        endcase
    end

    // Control decode from the state register; everything held at 0 in reset.
    always_comb begin
        inputPC      = 1'b0;
        valA         = 1'b0;
        writeSP      = 1'b0;
        regOrPC      = 1'b0;
        branch       = 1'b0;
        memAddr      = 2'b00;
        memWriteData = 2'b00;
        ALUsrca      = 2'b00;
        ALUsrcb      = 2'b00;
        ALUOp        = 4'b0000;
        writeOp      = 1'b0;
        writeA       = 1'b0;
        writeB       = 1'b0;
        writeDest    = 1'b0;
        writePC      = 1'b0;
        writeMem     = 1'b0;
        halted       = 1'b0;
        state_dbg    = 4'd0;
        if (reset) begin
            state_dbg = state_q;
            case (state_q)
                S_FETCH: begin
                    writeOp = 1'b1;
                    writePC = 1'b1;
                    ALUsrca = 2'b01;
                    ALUsrcb = 2'b01;
                end
                S_ADDR_A: begin
                    writeA  = 1'b1;
                    writePC = 1'b1;
                    ALUsrca = 2'b01;
                    ALUsrcb = 2'b10;
                end
                S_ADDR_B: begin
                    writeB  = 1'b1;
                    writePC = 1'b1;
                    ALUsrca = 2'b01;
                    ALUsrcb = 2'b10;
                end
                S_LOAD_A: begin
                    regOrPC = 1'b1;
                    memAddr = 2'b00;
                    writeA  = 1'b1;
                end
                S_LOAD_B: begin
                    regOrPC = 1'b1;
                    memAddr = 2'b01;
                    writeB  = 1'b1;
                end
                S_EXEC: begin
                    ALUOp     = alu_fn;
                    writeDest = 1'b1;
                    writeA    = 1'b1;
                end
                S_MOV: begin
                    ALUsrcb   = 2'b11;
                    writeDest = 1'b1;
                    writeA    = 1'b1;
                end
                S_WB: begin
                    writeMem     = 1'b1;
                    regOrPC      = 1'b1;
                    memAddr      = 2'b10;
                    memWriteData = 2'b01;
                    writePC      = 1'b1;
                    ALUsrca      = 2'b01;
                    ALUsrcb      = 2'b10;
                end
                S_CMP: begin
                    ALUOp = alu_fn;
                end
                S_BR: begin
                    writePC = 1'b1;
                    if (isTrue) begin
                        branch = 1'b1;
                    end else begin
                        ALUsrca = 2'b01;
                        ALUsrcb = 2'b10;
                    end
                end
                S_HALT: begin
`ifdef MM_CTRL_HALT_EN
                    halted = 1'b1;
`endif
                end
                default: state_dbg = state_q;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_control_unit.sv
// tb_mm_control_unit: directed + randomized check of the control FSM against
// an instruction-level model (per-class microstep list, per-step control set).
module tb_mm_control_unit;

    localparam int unsigned OP_W = 8;

    // Microstep names, numbered by the documented state_dbg encoding.
    localparam int FETCH  = 0;
    localparam int ADDR_A = 1;
    localparam int ADDR_B = 2;
    localparam int LOAD_A = 3;
    localparam int LOAD_B = 4;
    localparam int EXEC   = 5;
    localparam int MOV    = 6;
    localparam int WB     = 7;
    localparam int CMP    = 8;
    localparam int BR     = 9;
    localparam int HALT   = 10;

    typedef int seq_t[$];

    logic            CLK = 1'b0;
    logic            reset;
    logic [OP_W-1:0] op;
    logic            isTrue;
    logic            inputPC, valA, writeSP, regOrPC, branch;
    logic [1:0]      memAddr, memWriteData, ALUsrca, ALUsrcb;
    logic [3:0]      ALUOp;
    logic            writeOp, writeA, writeB, writeDest, writePC, writeMem, halted;
    logic [3:0]      state_dbg;
    logic [27:0]     obs;

    int vectors    = 0;
    int miscompares = 0;

    mm_control_unit #(.OP_W(OP_W)) dut (
        .CLK(CLK), .reset(reset), .op(op), .isTrue(isTrue),
        .inputPC(inputPC), .valA(valA), .writeSP(writeSP),
        .regOrPC(regOrPC), .branch(branch), .memAddr(memAddr),
        .memWriteData(memWriteData), .ALUsrca(ALUsrca), .ALUsrcb(ALUsrcb),
        .ALUOp(ALUOp), .writeOp(writeOp), .writeA(writeA), .writeB(writeB),
        .writeDest(writeDest), .writePC(writePC), .writeMem(writeMem),
        .halted(halted), .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    assign obs = {inputPC, valA, writeSP, regOrPC, branch, memAddr, memWriteData,
                  ALUsrca, ALUsrcb, ALUOp, writeOp, writeA, writeB, writeDest,
                  writePC, writeMem, halted, state_dbg};

    // Microstep list an instruction of the given class walks through.
    function automatic seq_t build_seq(input logic [1:0] cls);
        seq_t q;
        case (cls)
            2'b00:   q = '{FETCH, ADDR_A, ADDR_B, LOAD_A, LOAD_B, EXEC, WB};
            2'b01:   q = '{FETCH, ADDR_A, ADDR_B, LOAD_A, LOAD_B, CMP, BR};
            2'b10:   q = '{FETCH, ADDR_A, LOAD_A, MOV, WB};
            default: q = '{FETCH, ADDR_A};
        endcase
        return q;
    endfunction

    // Documented control set for one microstep.
    function automatic logic [27:0] exp_out(input int st, input logic [7:0] o, input logic t);
        logic       rpc, br, wop, wa, wb, wd, wpc, wm, h;
        logic [1:0] ma, mwd, sa, sb;
        logic [3:0] aop;
        {rpc, br, wop, wa, wb, wd, wpc, wm, h} = 9'b0;
        {ma, mwd, sa, sb} = 8'b0;
        aop = 4'b0;
        case (st)
            FETCH:  begin wop = 1; wpc = 1; sa = 2'b01; sb = 2'b01; end
            ADDR_A: begin wa = 1; wpc = 1; sa = 2'b01; sb = 2'b10; end
            ADDR_B: begin wb = 1; wpc = 1; sa = 2'b01; sb = 2'b10; end
            LOAD_A: begin rpc = 1; ma = 2'b00; wa = 1; end
            LOAD_B: begin rpc = 1; ma = 2'b01; wb = 1; end
            EXEC:   begin aop = o[3:0]; wd = 1; wa = 1; end
            MOV:    begin sb = 2'b11; wd = 1; wa = 1; end
            WB:     begin wm = 1; rpc = 1; ma = 2'b10; mwd = 2'b01; wpc = 1; sa = 2'b01; sb = 2'b10; end
            CMP:    begin aop = o[3:0]; end
            BR:     begin
                        wpc = 1;
                        if (t) br = 1;
                        else begin sa = 2'b01; sb = 2'b10; end
                    end
            HALT:   begin h = 1; end
            default: ;
        endcase
        return {3'b000, rpc, br, ma, mwd, sa, sb, aop, wop, wa, wb, wd, wpc, wm, h, 4'(st)};
    endfunction

    task automatic check(input string tag, input logic [27:0] e);
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    // One microstep: entered at posedge+1, checks at posedge+3, leaves at next posedge+1.
    // tm: 0/1 forces isTrue, anything else randomizes it.
    task automatic step(input int st, input int tm);
        isTrue = (tm == 0) ? 1'b0 : (tm == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        #2;
        check($sformatf("step%0d_op%02h_t%0b", st, op, isTrue), exp_out(st, op, isTrue));
        @(posedge CLK);
        #1;
    endtask

    // Runs an instruction from FETCH, optionally abandoning it after max_steps.
    task automatic run_instr(input logic [7:0] o, input int tm, input int max_steps);
        seq_t q;
        op = o;
        q = build_seq(o[7:6]);
        foreach (q[i]) begin
            if (max_steps >= 0 && i >= max_steps) break;
            step(q[i], tm);
        end
    endtask

    // Asynchronous reset pulse spanning two edges; all controls must read 0.
    task automatic pulse_reset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "_async"}, 28'h0);
        repeat (2) begin
            @(posedge CLK);
            #1;
            check({tag, "_held"}, 28'h0);
        end
        reset = 1'b1;
    endtask

    // Halt class tail: parked in HALT under the macro, otherwise straight back to FETCH.
    task automatic halt_tail(input int cycles);
`ifdef MM_CTRL_HALT_EN
        repeat (cycles) step(HALT, 2);
        pulse_reset("halt_exit");
`else
        if (cycles < 0) step(HALT, 2);
`endif
    endtask

    initial begin
        reset  = 1'b0;
        op     = '0;
        isTrue = 1'b0;
        #1;
        check("por", 28'h0);
        repeat (2) begin
            @(posedge CLK);
            #1;
            check("por_held", 28'h0);
        end
        reset = 1'b1;

        // Directed instructions.
        run_instr(8'h00, 2, -1);
        run_instr(8'h40, 1, -1);
        run_instr(8'h40, 0, -1);
        run_instr(8'h80, 2, -1);
        run_instr(8'h0A, 2, -1);
        run_instr(8'h47, 1, -1);
        run_instr(8'hC0, 2, -1);
        halt_tail(20);
        run_instr(8'h00, 2, -1);

        // Reset mid-instruction, then restart from FETCH.
        run_instr(8'h45, 2, 3);
        pulse_reset("rst_mid");
        run_instr(8'h83, 2, -1);

        // Reset while WB is driving writeMem.
        run_instr(8'h06, 2, 6);
        isTrue = 1'($urandom_range(0, 1));
        #2;
        check("wb_before_rst", exp_out(WB, op, isTrue));
        pulse_reset("rst_in_wb");
        run_instr(8'h01, 2, -1);

        // Randomized instruction stream with occasional aborts.
        repeat (60) begin
            logic [7:0] o;
            o = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                run_instr(o, 2, $urandom_range(1, 4));
                pulse_reset("rst_rand");
            end else begin
                run_instr(o, 2, -1);
                if (o[7:6] == 2'b11) halt_tail(3);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
